// File: rtl/snake_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : snake_matrix_scan
// Description : Scans an 8x8 LED matrix through a 16-bit 74HC595 chain.
//               Each row gets a {one-hot row select, active-low column} word
//               built from four snake cell indices. The snapshot is
//               frame-coherent, and the head can optionally blink.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_matrix_scan #(
    parameter int SHIFT_DIV    = 2,     // sys_clk cycles per shcp half-period
    parameter int ROW_DWELL    = 1000,  // sys_clk cycles a latched row is held
    parameter int BLINK_FRAMES = 32     // frames per head-blink toggle, 0 = off
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic [23:0] snake_body,
    input  logic        enable,
    output logic        ds,
    output logic        shcp,
    output logic        stcp,
    output logic [2:0]  row_idx,
    output logic        frame_start
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DWELL = 3'd4;

    localparam logic [7:0]  c_div_last     = 8'(SHIFT_DIV - 1);
    localparam logic [15:0] c_dwell_last   = 16'(ROW_DWELL - 1);
    localparam logic [15:0] c_blink_frames = 16'(BLINK_FRAMES);
    localparam bit          c_blink_en     = (BLINK_FRAMES != 0);

    logic [2:0]  r_state;
    logic [23:0] r_snap;        // body captured at the row-0 load
    logic        r_blink_off;   // running blink phase (1 = head dark)
    logic        r_frame_off;   // blink phase frozen for the current frame
    logic [15:0] r_frame_cnt;   // completed frames since last phase toggle
    logic [14:0] r_shreg;       // remaining bits after the one on ds
    logic [7:0]  r_div_cnt;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_dwell_cnt;
    logic        r_ds;
    logic        r_shcp;
    logic        r_stcp;
    logic [2:0]  r_row;
    logic        r_frame_start;

    logic [23:0] w_body;
    logic        w_head_off;
    logic [7:0]  w_lit;
    logic [15:0] w_word;

    // Build the shift word for the current row; row 0 uses the live input
    // and live blink phase because that is the cycle the snapshot is taken.
    always_comb begin
        w_body     = (r_row == 3'd0) ? snake_body : r_snap;
        w_head_off = (r_row == 3'd0) ? r_blink_off : r_frame_off;
        w_lit      = 8'h00;
        for (int s = 0; s < 4; s++) begin
            if ((w_body[23-6*s -: 3] == r_row) && !((s == 0) && w_head_off)) begin
                w_lit[w_body[20-6*s -: 3]] = 1'b1;
            end
        end
        w_word = {8'b1 << r_row, ~w_lit};
    end

    // Scan sequencer: row load, serial shift, latch strobe, dwell, frame wrap.
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_state       <= S_IDLE;
            r_snap        <= 24'd0;
            r_blink_off   <= 1'b0;
            r_frame_off   <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_shreg       <= 15'd0;
            r_div_cnt     <= 8'd0;
            r_bit_cnt     <= 4'd0;
            r_dwell_cnt   <= 16'd0;
            r_ds          <= 1'b0;
            r_shcp        <= 1'b0;
            r_stcp        <= 1'b0;
            r_row         <= 3'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state       <= S_LOAD;
                        r_frame_start <= (r_row == 3'd0);
                    end
                end

                S_LOAD: begin
                    r_shreg   <= w_word[14:0];
                    r_ds      <= w_word[15];
                    r_shcp    <= 1'b0;
                    r_div_cnt <= 8'd0;
                    r_bit_cnt <= 4'd0;
                    r_state   <= S_SHIFT;
                    if (r_row == 3'd0) begin
                        r_snap      <= snake_body;
                        r_frame_off <= r_blink_off;
                    end
                end

                S_SHIFT: begin
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= 8'd0;
                        if (!r_shcp) begin
                            r_shcp <= 1'b1;
                        end else begin
                            r_shcp <= 1'b0;
                            if (r_bit_cnt == 4'd15) begin
                                r_stcp  <= 1'b1;
                                r_state <= S_LATCH;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_ds      <= r_shreg[14];
                                r_shreg   <= {r_shreg[13:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                S_LATCH: begin
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt   <= 8'd0;
                        r_stcp      <= 1'b0;
                        r_dwell_cnt <= 16'd0;
                        r_state     <= S_DWELL;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                S_DWELL: begin
                    if (r_dwell_cnt == c_dwell_last) begin
                        r_dwell_cnt <= 16'd0;
                        if (r_row == 3'd7) begin
                            r_row <= 3'd0;
                            if (c_blink_en && ((r_frame_cnt + 16'd1) == c_blink_frames)) begin
                                r_frame_cnt <= 16'd0;
                                r_blink_off <= ~r_blink_off;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                            if (enable) begin
                                r_state       <= S_LOAD;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_row   <= r_row + 3'd1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ds          = r_ds;
    assign shcp        = r_shcp;
    assign stcp        = r_stcp;
    assign row_idx     = r_row;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_snake_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_matrix_scan
// Description : Scoreboard bench for snake_matrix_scan. A reference model
//               predicts all eight row words at every frame start, and a
//               monitor rebuilds each shifted word from ds/shcp at the stcp
//               strobe and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_matrix_scan;

    localparam int SD           = 2;
    localparam int RD           = 30;
    localparam int BF           = 2;
    localparam int ROW_PERIOD   = 1 + 32*SD + SD + RD;
    localparam int FRAME_PERIOD = 8 * ROW_PERIOD;

    logic        sys_clk     = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        enable      = 1'b0;
    logic [23:0] snake_body  = 24'd0;
    logic        ds;
    logic        shcp;
    logic        stcp;
    logic [2:0]  row_idx;
    logic        frame_start;

    int          checks   = 0;
    int          errors   = 0;
    int          n_frames = 0;
    logic [18:0] sb[$];

    // monitor state
    logic        prev_shcp = 1'b0;
    logic        prev_stcp = 1'b0;
    logic [15:0] cap       = 16'd0;
    int          nbits     = 0;
    int          stcp_w    = 0;
    longint      cyc       = 0;
    longint      last_fs   = -1;
    bit          gap       = 1'b0;
    bit          head_off;
    logic [18:0] exp_e;

    always #5 sys_clk = ~sys_clk;

    snake_matrix_scan #(
        .SHIFT_DIV   (SD),
        .ROW_DWELL   (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_reset_n(sys_reset_n),
        .snake_body (snake_body),
        .enable     (enable),
        .ds         (ds),
        .shcp       (shcp),
        .stcp       (stcp),
        .row_idx    (row_idx),
        .frame_start(frame_start)
    );

    // Reference: row select one-hot, columns lit by every segment in that row.
    function automatic logic [15:0] ref_word(input logic [23:0] body, input int r, input bit off);
        logic [7:0] lit;
        int         idx;
        lit = 8'd0;
        for (int s = 0; s < 4; s++) begin
            idx = int'((body >> (18 - 6*s)) & 24'd63);
            if ((idx / 8 == r) && !(s == 0 && off))
                lit = lit | (8'd1 << (idx % 8));
        end
        return {8'd1 << r, ~lit};
    endfunction

    // Model + monitor, sampled on the falling edge.
    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_reset_n) begin
            sb.delete();
            nbits     = 0;
            stcp_w    = 0;
            n_frames  = 0;
            last_fs   = -1;
            prev_shcp = 1'b0;
            prev_stcp = 1'b0;
        end else begin
            if (!enable) gap = 1'b1;
            if (frame_start) begin
                head_off = (BF > 0) ? (((n_frames / BF) % 2) == 1) : 1'b0;
                for (int r = 0; r < 8; r++)
                    sb.push_back({3'(r), ref_word(snake_body, r, head_off)});
                if (last_fs >= 0 && !gap) begin
                    checks++;
                    if (cyc - last_fs != FRAME_PERIOD) begin
                        errors++;
                        $display("FAIL frame_spacing: got %0d cycles, expected %0d", cyc - last_fs, FRAME_PERIOD);
                    end
                end
                last_fs = cyc;
                gap     = 1'b0;
                n_frames++;
            end
            if (shcp && !prev_shcp) begin
                cap = {cap[14:0], ds};
                nbits++;
            end
            if (stcp && !prev_stcp) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_stcp: row %0d word %h, nothing expected", row_idx, cap);
                end else begin
                    exp_e = sb.pop_front();
                    if ({row_idx, cap} !== exp_e || nbits != 16) begin
                        errors++;
                        $display("FAIL row_word: got row %0d word %h (%0d bits), expected row %0d word %h (16 bits)",
                                 row_idx, cap, nbits, exp_e[18:16], exp_e[15:0]);
                    end
                end
                nbits = 0;
            end
            if (stcp) begin
                stcp_w++;
            end else if (prev_stcp) begin
                checks++;
                if (stcp_w != SD) begin
                    errors++;
                    $display("FAIL stcp_width: got %0d cycles, expected %0d", stcp_w, SD);
                end
                stcp_w = 0;
            end
            prev_shcp = shcp;
            prev_stcp = stcp;
        end
    end

    task automatic wait_frames(input int target);
        int budget;
        int k;
        budget = (target - n_frames + 1) * FRAME_PERIOD + 100;
        k = 0;
        while (n_frames < target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        checks++;
        if (n_frames < target) begin
            errors++;
            $display("FAIL wait_frames: got %0d frames, expected %0d", n_frames, target);
        end
    endtask

    task automatic wait_row(input logic [2:0] r);
        int k;
        k = 0;
        while (row_idx != r && k < 2*FRAME_PERIOD) begin
            @(negedge sys_clk);
            k++;
        end
        checks++;
        if (row_idx != r) begin
            errors++;
            $display("FAIL wait_row: got row %0d, expected %0d", row_idx, r);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < FRAME_PERIOD + 100) begin
            @(negedge sys_clk);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d rows pending, expected 0", sb.size());
        end
    endtask

    task automatic drive_step();
        @(posedge sys_clk);
        #2;
    endtask

    int          saved_frames;
    logic [5:0]  a, b, c;
    int          k;

    initial begin
        snake_body  = {6'd44, 6'd45, 6'd46, 6'd47};
        sys_reset_n = 1'b0;
        enable      = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({ds, shcp, stcp, row_idx, frame_start} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000", {ds, shcp, stcp, row_idx, frame_start});
        end
        drive_step();
        sys_reset_n = 1'b1;
        enable      = 1'b1;

        // Straight snake in row 5 over two full blink periods.
        wait_frames(5);

        // All segments on cell 0, switched in mid-frame.
        wait_row(3'd3);
        drive_step();
        snake_body = 24'd0;
        wait_frames(9);

        // Random bodies, each changed during row 3 of a running frame.
        for (int i = 0; i < 6; i++) begin
            wait_row(3'd3);
            drive_step();
            a = 6'($urandom);
            b = 6'($urandom);
            c = 6'($urandom);
            if ($urandom_range(0, 2) == 0)
                snake_body = {a, a, b, c};
            else if ($urandom_range(0, 1) == 0)
                snake_body = {a, b, a, a};
            else
                snake_body = 24'($urandom);
            wait_frames(n_frames + 1);
        end

        // Drop enable during row 2: frame must finish, then stay idle.
        wait_row(3'd2);
        drive_step();
        enable = 1'b0;
        saved_frames = n_frames;
        wait_drain();
        repeat (3 * ROW_PERIOD) @(negedge sys_clk);
        checks++;
        if (n_frames != saved_frames || row_idx != 3'd0 || shcp != 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL idle_after_disable: got frames %0d row %0d shcp %b pending %0d, expected frames %0d row 0 shcp 0 pending 0",
                     n_frames, row_idx, shcp, sb.size(), saved_frames);
        end

        // Reset pulse in the middle of row 3 shifting.
        drive_step();
        enable = 1'b1;
        wait_row(3'd3);
        k = 0;
        while (!(shcp && row_idx == 3'd3) && k < 2*ROW_PERIOD) begin
            @(negedge sys_clk);
            k++;
        end
        drive_step();
        sys_reset_n = 1'b0;
        @(posedge sys_clk);
        #1;
        checks++;
        if ({ds, shcp, stcp, row_idx, frame_start} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_shift: got %b, expected 0000000", {ds, shcp, stcp, row_idx, frame_start});
        end
        #1;
        sys_reset_n = 1'b1;
        snake_body  = {6'd9, 6'd18, 6'd27, 6'd9};
        wait_frames(3);

        // Wind down and confirm every predicted row was delivered.
        drive_step();
        enable = 1'b0;
        wait_drain();
        repeat (2 * ROW_PERIOD) @(negedge sys_clk);
        checks++;
        if (sb.size() != 0 || n_frames != 3) begin
            errors++;
            $display("FAIL final_idle: got pending %0d frames %0d, expected pending 0 frames 3", sb.size(), n_frames);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
